// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder family.
package adder_pkg;

    function automatic bit legal_cfg(input int size, input int stages);
        return (stages >= 1) && (stages <= size) && ((size % stages) == 0);
    endfunction

endpackage

// File: rtl/add_nbit_gen.sv
// Combinational SIZE-bit ripple-carry adder built from full_adder cells.
module add_nbit_gen #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            ci,
    output logic [SIZE-1:0] s,
    output logic            co
);

    logic [SIZE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SIZE; i++) begin : g_bit
        full_adder u_fa (
            .a (a[i]),
            .b (b[i]),
            .ci(c[i]),
            .s (s[i]),
            .co(c[i+1])
        );
    end

    assign co = c[SIZE];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_nbit_pipe.sv
// Pipelined SIZE-bit add/sub: one W-bit slice per stage, carry registered between
// stages, operand skew / result deskew, valid/ready handshake with backpressure.
module add_nbit_pipe
    import adder_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            ci,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] s,
    output logic            co,
    output logic            ovf
);

    if (!legal_cfg(SIZE, STAGES)) begin : g_cfg_check
        $error("add_nbit_pipe: STAGES must be in 1..SIZE and divide SIZE");
    end

    localparam int W = SIZE / STAGES;

    logic [SIZE-1:0] b_eff;
    logic            c_eff;
    logic [STAGES:0] en;

    // Subtraction is a + ~b + 1, so ci is overridden by the forced carry-in.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | ci;

    // A stage may load when it is empty or its successor is loading this cycle.
    assign en[STAGES] = out_ready;
    assign in_ready   = en[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [W-1:0]         opa;
        logic [W-1:0]         opb;
        logic [W-1:0]         slice_s;
        logic                 cin;
        logic                 slice_c;
        logic                 amsb;
        logic                 bmsb;
        logic                 vin;
        logic [(k+1)*W-1:0]   sum_d;
        logic [(k+1)*W-1:0]   sum_p;
        logic                 co_p;
        logic                 vld_p;

        if (k == 0) begin : g_src
            assign opa   = a[W-1:0];
            assign opb   = b_eff[W-1:0];
            assign cin   = c_eff;
            assign amsb  = a[SIZE-1];
            assign bmsb  = b_eff[SIZE-1];
            assign vin   = in_valid;
            assign sum_d = slice_s;
        end else begin : g_src
            assign opa   = g_st[k-1].g_fwd.a_p[W-1:0];
            assign opb   = g_st[k-1].g_fwd.b_p[W-1:0];
            assign cin   = g_st[k-1].co_p;
            assign amsb  = g_st[k-1].g_fwd.amsb_p;
            assign bmsb  = g_st[k-1].g_fwd.bmsb_p;
            assign vin   = g_st[k-1].vld_p;
            assign sum_d = {slice_s, g_st[k-1].sum_p};
        end

        assign en[k] = ~vld_p | en[k+1];

        add_nbit_gen #(.SIZE(W)) u_add (
            .a (opa),
            .b (opb),
            .ci(cin),
            .s (slice_s),
            .co(slice_c)
        );

        // ---- stage k boundary: accumulated low sum slices, slice carry, valid ----
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= 1'b0;
                sum_p <= '0;
                co_p  <= 1'b0;
            end else if (en[k]) begin
                vld_p <= vin;
                sum_p <= sum_d;
                co_p  <= slice_c;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [SIZE-(k+1)*W-1:0] a_d;
            logic [SIZE-(k+1)*W-1:0] b_d;
            logic [SIZE-(k+1)*W-1:0] a_p;
            logic [SIZE-(k+1)*W-1:0] b_p;
            logic                    amsb_p;
            logic                    bmsb_p;

            // Only the operand slices not yet consumed travel onward.
            if (k == 0) begin : g_fsrc
                assign a_d = a[SIZE-1:W];
                assign b_d = b_eff[SIZE-1:W];
            end else begin : g_fsrc
                assign a_d = g_st[k-1].g_fwd.a_p[SIZE-k*W-1:W];
                assign b_d = g_st[k-1].g_fwd.b_p[SIZE-k*W-1:W];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_p    <= '0;
                    b_p    <= '0;
                    amsb_p <= 1'b0;
                    bmsb_p <= 1'b0;
                end else if (en[k]) begin
                    a_p    <= a_d;
                    b_p    <= b_d;
                    amsb_p <= amsb;
                    bmsb_p <= bmsb;
                end
            end
        end else begin : g_last
            logic ovf_p;

            // ---- output boundary: signed overflow from the MSB slice ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_p <= 1'b0;
                end else if (en[k]) begin
                    ovf_p <= (amsb == bmsb) && (slice_s[W-1] != amsb);
                end
            end
        end
    end

    assign s         = g_st[STAGES-1].sum_p;
    assign co        = g_st[STAGES-1].co_p;
    assign ovf       = g_st[STAGES-1].g_last.ovf_p;
    assign out_valid = g_st[STAGES-1].vld_p;

endmodule

// File: tb/tb_add_nbit_pipe.sv
// Bench for add_nbit_pipe: directed and random add/sub traffic against an arithmetic
// reference model, plus STAGES=1 and STAGES=SIZE builds.
module tb_add_nbit_pipe;

    localparam int     SIZE   = 32;
    localparam int     STAGES = 4;
    localparam longint SMAX   = 64'sd2147483647;
    localparam longint SMIN   = -64'sd2147483648;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            ci;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] s;
    logic            co;
    logic            ovf;

    logic            in_ready1, ov1, co1, ovf1;
    logic [SIZE-1:0] s1;
    logic            in_ready32, ov32, co32, ovf32;
    logic [SIZE-1:0] s32;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   acc    = 0;
    bit   chk_lat = 1'b0;
    bit   chk_rdy = 1'b0;

    always #5 clk = ~clk;

    add_nbit_pipe #(.SIZE(SIZE), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf)
    );

    add_nbit_pipe #(.SIZE(SIZE), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(ov1), .out_ready(1'b1), .s(s1), .co(co1), .ovf(ovf1)
    );

    add_nbit_pipe #(.SIZE(SIZE), .STAGES(SIZE)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(ov32), .out_ready(1'b1), .s(s32), .co(co32), .ovf(ovf32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference: true integer arithmetic; overflow means the signed result leaves 32-bit range.
    function automatic exp_t model(input logic [31:0] a_, input logic [31:0] b_,
                                   input logic ci_, input logic sub_);
        exp_t        e;
        longint      r;
        logic [32:0] u;
        if (sub_) begin
            e.s  = a_ - b_;
            e.co = (a_ >= b_);
            r    = longint'($signed(a_)) - longint'($signed(b_));
        end else begin
            u    = {1'b0, a_} + {1'b0, b_} + {32'd0, ci_};
            e.s  = u[31:0];
            e.co = u[32];
            r    = longint'($signed(a_)) + longint'($signed(b_)) + longint'(ci_);
        end
        e.ovf = (r > SMAX) || (r < SMIN);
        e.cyc = 0;
        return e;
    endfunction

    // One clock: observe mid-cycle, score the handshake, advance past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_s", s, 32'd0);
            chk("rst_co", co, 1'b0);
            chk("rst_ovf", ovf, 1'b0);
            chk("rst_in_ready", in_ready, 1'b1);
        end else begin
            if (chk_rdy) chk("stream_in_ready", in_ready, 1'b1);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("out_with_empty_sb", out_valid, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chk("s", s, e.s);
                    chk("co", co, e.co);
                    chk("ovf", ovf, e.ovf);
                    if (chk_lat) chk("latency", cyc - e.cyc, STAGES);
                end
            end
            if (in_valid && in_ready) begin
                e     = model(a, b, ci, sub);
                e.cyc = cyc;
                sbq.push_back(e);
                acc++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a_, input logic [31:0] b_,
                          input logic ci_, input logic sub_);
        a = a_; b = b_; ci = ci_; sub = sub_; in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] a_, input logic [31:0] b_,
                        input logic ci_, input logic sub_);
        set_op(a_, b_, ci_, sub_);
        cycle();
    endtask

    task automatic rand_send();
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        int acc0;
        int target;
        int n;
        int lat1;
        int lat32;

        set_op($urandom, $urandom, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;

        chk_lat = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        idle(6);
        chk("directed_drained", sbq.size(), 0);

        chk_rdy = 1'b1;
        repeat (8) rand_send();
        idle(6);
        chk_rdy = 1'b0;
        chk("stream_drained", sbq.size(), 0);

        chk_lat   = 1'b0;
        out_ready = 1'b0;
        acc0      = acc;
        repeat (6) rand_send();
        chk("bp_accepted", acc - acc0, 4);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        idle(6);
        chk("bp_drained", sbq.size(), 0);

        acc0   = acc;
        target = acc + 1000;
        n      = 0;
        while (acc < target && n < 20000) begin
            set_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            n++;
        end
        chk("random_accepted", acc - acc0, 1000);
        out_ready = 1'b1;
        idle(8);
        chk("random_drained", sbq.size(), 0);

        out_ready = 1'b0;
        repeat (3) rand_send();
        idle(3);
        chk("pre_rst_out_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        chk("async_rst_s", s, 32'd0);
        sbq.delete();
        repeat (2) cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(10);

        chk("aux_in_ready", {in_ready1, in_ready32}, 2'b11);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        in_valid = 1'b0;
        lat1  = -1;
        lat32 = -1;
        n     = 1;
        while (n <= 60 && (lat1 < 0 || lat32 < 0)) begin
            if (ov1 && lat1 < 0) begin
                lat1 = n;
                chk("st1_s", s1, 32'h8000_0000);
                chk("st1_co", co1, 1'b0);
                chk("st1_ovf", ovf1, 1'b1);
            end
            if (ov32 && lat32 < 0) begin
                lat32 = n;
                chk("st32_s", s32, 32'h8000_0000);
                chk("st32_co", co32, 1'b0);
                chk("st32_ovf", ovf32, 1'b1);
            end
            if (lat1 < 0 || lat32 < 0) begin
                cycle();
                n++;
            end
        end
        chk("st1_latency", lat1, 1);
        chk("st32_latency", lat32, 32);
        idle(4);
        chk("final_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
